multi_counter_bank: RTL



---
 rtl/multi_counter_bank.sv | 90 +++++++++
 1 files changed

// File: rtl/multi_counter_bank.sv
// Bank of NUM_CH independent up/down counters with per-channel limit, wrap/saturate,
// load, terminal-count pulse, sticky overflow and a coherent all-channel snapshot.
module multi_counter_bank #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       up_dn,
  input  logic [NUM_CH-1:0]       sat_mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  input  logic [NUM_CH-1:0]       ovf_clr,
  input  logic                    snap,
  output logic [NUM_CH*WIDTH-1:0] cnt,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH*WIDTH-1:0] snap_cnt,
  output logic                    snap_valid
);

  logic [NUM_CH*WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH*WIDTH-1:0] snap_cnt_q, snap_cnt_d;
  logic [NUM_CH-1:0]       tc_q, tc_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic                    snap_valid_q, snap_valid_d;

  // One enabled step: returns {terminal, next_count}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] cur,
                                          input logic [WIDTH-1:0] lim,
                                          input logic             up,
                                          input logic             sat);
    logic [WIDTH:0] r;
    if (up) begin
      if (cur < lim) r = {1'b0, cur + WIDTH'(1)};
      else           r = {1'b1, (sat ? lim : WIDTH'(0))};
    end else begin
      if (cur != '0) r = {1'b0, cur - WIDTH'(1)};
      else           r = {1'b1, (sat ? WIDTH'(0) : lim)};
    end
    return r;
  endfunction

  always_comb begin
    logic [WIDTH:0] res;
    cnt_d        = cnt_q;
    tc_d         = '0;
    ovf_d        = ovf_q;
    res          = '0;
    snap_valid_d = snap;
    snap_cnt_d   = snap ? cnt_q : snap_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      res = '0;
      if (load[i]) begin
        cnt_d[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        res = step(cnt_q[i*WIDTH +: WIDTH], limit[i*WIDTH +: WIDTH], up_dn[i], sat_mode[i]);
        cnt_d[i*WIDTH +: WIDTH] = res[WIDTH-1:0];
      end
      tc_d[i] = res[WIDTH];
      // A terminal event in the same cycle as a clear keeps the flag set.
      ovf_d[i] = res[WIDTH] | (ovf_q[i] & ~ovf_clr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      tc_q         <= '0;
      ovf_q        <= '0;
      snap_cnt_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tc_q         <= tc_d;
      ovf_q        <= ovf_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign cnt        = cnt_q;
  assign tc         = tc_q;
  assign ovf        = ovf_q;
  assign snap_cnt   = snap_cnt_q;
  assign snap_valid = snap_valid_q;

endmodule
